// File: rtl/hzd_scoreboard_unit.sv
// Load-use hazard unit: per-register countdown scoreboard that stalls ID while a load result is pending.
// Optional stall-cycle performance counter enabled by defining HZD_STALL_PERF_EN.
module hzd_scoreboard_unit #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] IF_ID_Rs,
  input  logic [ADDR_W-1:0] IF_ID_Rt,
  input  logic              id_uses_rt,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              flush,
  output logic              Sel,
  output logic              IF_ID_ld,
  output logic              PC_ld,
  output logic              stall
`ifdef HZD_STALL_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  input  logic              stall_cycles_clr
`endif
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  busy;
  logic             haz;
  logic             issue;
  logic             sb_write;

  always_comb begin
    busy = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      busy[i] = (cnt[i] != '0);
    end
  end

  // busy[0] is constant 0, so the explicit !=0 terms only mirror the register-0 exemption
  always_comb begin
    haz = id_valid && !flush &&
          ((busy[IF_ID_Rs] && (IF_ID_Rs != '0)) ||
           (id_uses_rt && busy[IF_ID_Rt] && (IF_ID_Rt != '0)));
    issue    = id_valid && !flush && !haz;
    sb_write = issue && id_reg_write && (id_rd != '0);
  end

  assign Sel      = ~haz;
  assign IF_ID_ld = ~haz;
  assign PC_ld    = ~haz;
  assign stall    = haz;

  always_ff @(posedge clk) begin
    cnt[0] <= '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (rst) begin
        cnt[i] <= '0;
      end else if (sb_write && (id_rd == ADDR_W'(i))) begin
        cnt[i] <= id_mem_read ? CNT_W'(LOAD_LAT) : '0;
      end else if (cnt[i] != '0) begin
        cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

`ifdef HZD_STALL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || stall_cycles_clr) begin
      stall_cycles <= '0;
    end else if (haz && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hzd_scoreboard_unit.sv
// Bench: three scoreboard instances (LOAD_LAT 1/2/3) share stimulus; a per-register
// ready-edge timestamp model predicts the stall outputs of each.
module tb_hzd_scoreboard_unit;

  logic       clk = 1'b0;
  logic       rst, id_valid, id_uses_rt, id_mem_read, id_reg_write, flush;
  logic [4:0] IF_ID_Rs, IF_ID_Rt, id_rd;
  logic       sel [3];
  logic       ifld[3];
  logic       pcld[3];
  logic       stl [3];

  always #5 clk = ~clk;

  hzd_scoreboard_unit #(.ADDR_W(5), .LOAD_LAT(1), .CNT_W(4)) u_lat1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
    .id_uses_rt(id_uses_rt), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
    .id_rd(id_rd), .flush(flush), .Sel(sel[0]), .IF_ID_ld(ifld[0]), .PC_ld(pcld[0]), .stall(stl[0]));
  hzd_scoreboard_unit #(.ADDR_W(5), .LOAD_LAT(2), .CNT_W(4)) u_lat2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
    .id_uses_rt(id_uses_rt), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
    .id_rd(id_rd), .flush(flush), .Sel(sel[1]), .IF_ID_ld(ifld[1]), .PC_ld(pcld[1]), .stall(stl[1]));
  hzd_scoreboard_unit #(.ADDR_W(5), .LOAD_LAT(3), .CNT_W(4)) u_lat3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
    .id_uses_rt(id_uses_rt), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
    .id_rd(id_rd), .flush(flush), .Sel(sel[2]), .IF_ID_ld(ifld[2]), .PC_ld(pcld[2]), .stall(stl[2]));

  int n_chk  = 0;
  int n_pass = 0;

  // Model: edge index at which each register's pending load result becomes usable.
  int lat [3] = '{1, 2, 3};
  int ready [3][32];
  int edge_no = 0;
  logic last_stall [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic model_haz(input int k);
    logic rs_wait, rt_wait;
    rs_wait = (IF_ID_Rs != 5'd0) && (ready[k][IF_ID_Rs] > edge_no);
    rt_wait = id_uses_rt && (IF_ID_Rt != 5'd0) && (ready[k][IF_ID_Rt] > edge_no);
    return id_valid && !flush && (rs_wait || rt_wait);
  endfunction

  task automatic step(input logic r, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic mr, input logic rw, input logic [4:0] rd,
                      input logic fl);
    logic h;
    @(negedge clk);
    rst = r; id_valid = v; IF_ID_Rs = rs; IF_ID_Rt = rt; id_uses_rt = urt;
    id_mem_read = mr; id_reg_write = rw; id_rd = rd; flush = fl;
    #1;
    for (int k = 0; k < 3; k++) begin
      h = model_haz(k);
      check($sformatf("lat%0d_e%0d_outs", lat[k], edge_no),
            {28'd0, sel[k], ifld[k], pcld[k], stl[k]}, {28'd0, ~h, ~h, ~h, h});
      last_stall[k] = stl[k];
      if (r) begin
        for (int j = 0; j < 32; j++) ready[k][j] = 0;
      end else if (v && !fl && !h && rw && rd != 5'd0) begin
        ready[k][rd] = mr ? edge_no + lat[k] + 1 : 0;
      end
    end
    edge_no++;
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load(input logic [4:0] rd);
    step(0, 1, 5'd1, 5'd2, 0, 1, 1, rd, 0);
  endtask

  // Holds a dependent ALU instruction in ID until instance k lets it through.
  task automatic dep(input int k, input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                     output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, rs, rt, urt, 0, 1, 5'd20, 0);
      if (!last_stall[k]) break;
      n++;
    end
  endtask

  initial begin
    int n;
    rst = 1; id_valid = 0; IF_ID_Rs = 0; IF_ID_Rt = 0; id_uses_rt = 0;
    id_mem_read = 0; id_reg_write = 0; id_rd = 0; flush = 0;
    for (int k = 0; k < 3; k++) for (int j = 0; j < 32; j++) ready[k][j] = 0;

    do_reset();
    load(5'd8);  dep(0, 5'd8, 5'd0, 0, n); check("lat1_r8_rs_stalls", n, 1);

    do_reset();
    load(5'd5);  dep(2, 5'd0, 5'd5, 1, n); check("lat3_r5_rt_stalls", n, 3);
    do_reset();
    load(5'd5);  dep(2, 5'd0, 5'd5, 0, n); check("lat3_r5_rt_unused", n, 0);

    do_reset();
    load(5'd0);  dep(2, 5'd0, 5'd0, 1, n); check("lat3_r0_exempt", n, 0);
    do_reset();
    load(5'd9);  dep(2, 5'd10, 5'd0, 0, n); check("lat3_r9_vs_r10", n, 0);

    do_reset();
    load(5'd4);
    step(0, 1, 5'd4, 5'd0, 0, 0, 1, 5'd20, 1);
    check("lat2_flush_no_stall", {31'd0, last_stall[1]}, 32'd0);
    dep(1, 5'd4, 5'd0, 0, n); check("lat2_after_flush", n, 1);

    do_reset();
    load(5'd5);
    step(0, 1, 5'd5, 5'd0, 0, 0, 1, 5'd20, 0);
    check("lat3_stall_before_rst", {31'd0, last_stall[2]}, 32'd1);
    step(1, 1, 5'd5, 5'd0, 0, 0, 1, 5'd20, 0);
    step(0, 1, 5'd5, 5'd0, 0, 0, 1, 5'd20, 0);
    check("lat3_after_rst", {31'd0, last_stall[2]}, 32'd0);

    // Back-to-back loads to one register: second load reloads the latency.
    do_reset();
    load(5'd6); load(5'd6); dep(2, 5'd6, 5'd6, 1, n); check("lat3_reload", n, 3);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) != 0),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) != 0),
           5'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
